// File: rtl/obstacle_controller.sv
// -----------------------------------------------------------------------------
// obstacle_controller
//
// Control FSM for the obstacle-course bouncing-pixel demo. Each loop draws the
// pixel, waits one timer period, erases it, probes the obstacle memory on the
// y axis and then the x axis (reflecting direction on a hit) and finally steps
// the pixel one place diagonally.
//
// Optional feature: define OBSTACLE_HIT_COUNT_EN to add the saturating `hits`
// collision counter and its output port. Without the macro the port and the
// counter do not exist.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   start              level, only looked at in IDLE
//   xdir, ydir         current direction flags from the datapath (1 = +)
//   timer_done         datapath timer has reached its limit
//   obstacle           registered obstacle-memory read of the probed pixel
//   en_xpos/en_ypos    position register enables
//   s_xpos/s_ypos      0 = load centre, 1 = decrement, 2 = increment
//   en_xdir/en_ydir    direction register enables
//   s_xdir/s_ydir      0 = set to 1, 1 = toggle
//   en_timer/s_timer   timer enable; select 0 = clear, 1 = count
//   s_color            1 = green, 0 = black
//   s_obs_xy           probe select: 0 = up, 1 = down, 2 = left, 3 = right
//   plot               VGA write strobe
//   dbg_state          current FSM state, for observation only
//   hits               saturating collision count (OBSTACLE_HIT_COUNT_EN only)
// -----------------------------------------------------------------------------
module obstacle_controller #(
    parameter int HIT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       xdir,
    input  logic       ydir,
    input  logic       timer_done,
    input  logic       obstacle,
    output logic       en_xpos,
    output logic       en_ypos,
    output logic [1:0] s_xpos,
    output logic [1:0] s_ypos,
    output logic       en_xdir,
    output logic       en_ydir,
    output logic       s_xdir,
    output logic       s_ydir,
    output logic       en_timer,
    output logic       s_timer,
    output logic       s_color,
    output logic [1:0] s_obs_xy,
    output logic       plot,
    output logic [3:0] dbg_state
`ifdef OBSTACLE_HIT_COUNT_EN
    ,
    output logic [HIT_WIDTH-1:0] hits
`endif
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_DRAW  = 4'd2,
        S_WAIT  = 4'd3,
        S_ERASE = 4'd4,
        S_CHK_Y = 4'd5,
        S_RD_Y  = 4'd6,
        S_CHK_X = 4'd7,
        S_RD_X  = 4'd8,
        S_MOVE  = 4'd9
    } state_t;

    state_t state_q, state_d;

    if (HIT_WIDTH < 1) begin : g_bad_hit_width
        $error("HIT_WIDTH must be at least 1");
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        en_xpos  = 1'b0;
        en_ypos  = 1'b0;
        s_xpos   = 2'd0;
        s_ypos   = 2'd0;
        en_xdir  = 1'b0;
        en_ydir  = 1'b0;
        s_xdir   = 1'b0;
        s_ydir   = 1'b0;
        en_timer = 1'b0;
        s_timer  = 1'b0;
        s_color  = 1'b0;
        s_obs_xy = 2'd0;
        plot     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                // Centre the pixel, point it down-right, clear the timer.
                en_xpos  = 1'b1;
                en_ypos  = 1'b1;
                en_xdir  = 1'b1;
                en_ydir  = 1'b1;
                en_timer = 1'b1;
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                plot    = 1'b1;
                s_color = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                en_timer = 1'b1;
                s_timer  = 1'b1;
                if (timer_done) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                // Clearing the timer here leaves it at zero for the next WAIT.
                plot     = 1'b1;
                en_timer = 1'b1;
                state_d  = S_CHK_Y;
            end
            S_CHK_Y: begin
                // Address is presented here; the RAM answers next cycle.
                s_obs_xy = ydir ? 2'd1 : 2'd0;
                state_d  = S_RD_Y;
            end
            S_RD_Y: begin
                s_obs_xy = ydir ? 2'd1 : 2'd0;
                en_ydir  = obstacle;
                s_ydir   = 1'b1;
                state_d  = S_CHK_X;
            end
            S_CHK_X: begin
                s_obs_xy = xdir ? 2'd3 : 2'd2;
                state_d  = S_RD_X;
            end
            S_RD_X: begin
                s_obs_xy = xdir ? 2'd3 : 2'd2;
                en_xdir  = obstacle;
                s_xdir   = 1'b1;
                state_d  = S_MOVE;
            end
            S_MOVE: begin
                // Direction registers updated in RD_Y/RD_X are already
                // visible, so a reflected axis steps the other way.
                en_xpos = 1'b1;
                en_ypos = 1'b1;
                s_xpos  = xdir ? 2'd2 : 2'd1;
                s_ypos  = ydir ? 2'd2 : 2'd1;
                state_d = S_DRAW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef OBSTACLE_HIT_COUNT_EN
    logic [HIT_WIDTH-1:0] hits_q, hits_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    // One count per axis read that sees an obstacle; holds at all-ones.
    always_comb begin
        hits_d = hits_q;
        if (state_q == S_INIT) begin
            hits_d = '0;
        end else if ((state_q == S_RD_Y || state_q == S_RD_X) && obstacle &&
                     (hits_q != {HIT_WIDTH{1'b1}})) begin
            hits_d = hits_q + 1'b1;
        end
    end

    assign hits = hits_q;
`endif

endmodule

// File: tb/tb_obstacle_controller.sv
// -----------------------------------------------------------------------------
// tb_obstacle_controller
//
// Bench for obstacle_controller with a small datapath and obstacle memory
// attached (timer limit L = 2, so a loop is 10 cycles). Expected plots come
// from a per-loop model of the bouncing pixel; `hits` is checked when
// OBSTACLE_HIT_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_obstacle_controller;

    localparam int TLIM = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       xdir, ydir, timer_done, obstacle;
    logic       en_xpos, en_ypos, en_xdir, en_ydir, s_xdir, s_ydir;
    logic [1:0] s_xpos, s_ypos, s_obs_xy;
    logic       en_timer, s_timer, s_color, plot;
    logic [3:0] dbg_state;
`ifdef OBSTACLE_HIT_COUNT_EN
    logic [7:0] hits;
`endif

    obstacle_controller #(.HIT_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .xdir(xdir), .ydir(ydir), .timer_done(timer_done), .obstacle(obstacle),
        .en_xpos(en_xpos), .en_ypos(en_ypos), .s_xpos(s_xpos), .s_ypos(s_ypos),
        .en_xdir(en_xdir), .en_ydir(en_ydir), .s_xdir(s_xdir), .s_ydir(s_ydir),
        .en_timer(en_timer), .s_timer(s_timer), .s_color(s_color),
        .s_obs_xy(s_obs_xy), .plot(plot), .dbg_state(dbg_state)
`ifdef OBSTACLE_HIT_COUNT_EN
        , .hits(hits)
`endif
    );

    logic [15:0] outs;
    assign outs = {en_xpos, en_ypos, s_xpos, s_ypos, en_xdir, en_ydir, s_xdir,
                   s_ydir, en_timer, s_timer, s_color, s_obs_xy, plot};

    // ---------------- datapath + obstacle memory ----------------
    bit         obs_mem [256][128];
    logic [7:0] xpos = 8'd0;
    logic [6:0] ypos = 7'd0;
    logic       xdir_r = 1'b0, ydir_r = 1'b0;
    logic [3:0] tcnt = 4'd0;
    logic       obs_r = 1'b0;
    logic       force_obs = 1'b0;
    logic [7:0] px;
    logic [6:0] py;

    assign xdir = xdir_r;
    assign ydir = ydir_r;
    assign timer_done = (tcnt == 4'(TLIM));
    assign obstacle = obs_r;

    always_comb begin
        px = xpos;
        py = ypos;
        case (s_obs_xy)
            2'd0: py = ypos - 7'd1;
            2'd1: py = ypos + 7'd1;
            2'd2: px = xpos - 8'd1;
            default: px = xpos + 8'd1;
        endcase
    end

    always @(posedge clk) begin
        if (en_xpos) xpos <= (s_xpos == 2'd0) ? 8'd80 : (s_xpos == 2'd1) ? xpos - 8'd1 : xpos + 8'd1;
        if (en_ypos) ypos <= (s_ypos == 2'd0) ? 7'd60 : (s_ypos == 2'd1) ? ypos - 7'd1 : ypos + 7'd1;
        if (en_xdir) xdir_r <= s_xdir ? ~xdir_r : 1'b1;
        if (en_ydir) ydir_r <= s_ydir ? ~ydir_r : 1'b1;
        if (en_timer) tcnt <= s_timer ? tcnt + 4'd1 : 4'd0;
        obs_r <= force_obs | obs_mem[px][py];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];   // {color, x[7:0], y[6:0]}
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic        m_xd, m_yd;
    int          m_hits;

    task automatic model_reset();
        m_x = 8'd80; m_y = 7'd60; m_xd = 1'b1; m_yd = 1'b1; m_hits = 0;
    endtask

    task automatic model_loops(input int n);
        logic [7:0] nx;
        logic [6:0] ny;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, m_x, m_y});
            exp_q.push_back({1'b0, m_x, m_y});
            ny = m_yd ? m_y + 7'd1 : m_y - 7'd1;
            if (obs_mem[m_x][ny]) begin
                m_yd = ~m_yd;
                if (m_hits < 255) m_hits++;
            end
            nx = m_xd ? m_x + 8'd1 : m_x - 8'd1;
            if (obs_mem[nx][m_y]) begin
                m_xd = ~m_xd;
                if (m_hits < 255) m_hits++;
            end
            m_x = m_xd ? m_x + 8'd1 : m_x - 8'd1;
            m_y = m_yd ? m_y + 7'd1 : m_y - 7'd1;
        end
    endtask

    // ---------------- plot monitor / scoreboard ----------------
    bit sb_en = 1'b1;
    bit have_draw = 1'b0, have_erase = 1'b0;
    int last_draw = 0, last_erase = 0;

    always @(negedge clk) begin
        if (resetn && plot) begin
            if (sb_en) begin
                if (exp_q.size() == 0) check("unexpected_plot", 1, 0);
                else check("plot_pixel", {s_color, xpos, ypos}, exp_q.pop_front());
            end
            if (s_color) begin
                if (have_erase) check("gap_erase_to_draw", cyc - last_erase, 6);
                last_draw = cyc;
                have_draw = 1'b1;
            end else begin
                if (have_draw) check("gap_draw_to_erase", cyc - last_draw, TLIM + 2);
                last_erase = cyc;
                have_erase = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                obs_mem[x][y] = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        have_draw = 1'b0;
        have_erase = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int idle_cycles);
        resetn = 1'b1;
        repeat (idle_cycles) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_draws(input int n);
        int seen = 0;
        for (int c = 0; c < 3000 && seen < n; c++) begin
            @(negedge clk);
            if (plot && s_color) seen++;
        end
        if (seen < n) check("wait_draws_timeout", seen, n);
    endtask

    // Wait for the queue to empty (last erase), then to MOVE of that loop.
    task automatic finish_run();
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (TLIM + 3) @(negedge clk);
`ifdef OBSTACLE_HIT_COUNT_EN
        check("hits_after_run", hits, m_hits);
`endif
        do_reset();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_mem();
        #1;
        check("reset_outputs_zero", outs, 0);
`ifdef OBSTACLE_HIT_COUNT_EN
        check("reset_hits_zero", hits, 0);
`endif
        repeat (2) @(negedge clk);

        // Start timing: INIT outputs, then DRAW; then reset during WAIT.
        model_reset();
        exp_q.push_back({1'b1, 8'd80, 7'd60});
        pulse_start(1);
        check("init_outputs", outs, {1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        @(negedge clk);
        check("first_draw_plot", {plot, s_color}, 2'b11);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", outs, 0);
`ifdef OBSTACLE_HIT_COUNT_EN
        check("async_reset_hits", hits, 0);
`endif
        @(negedge clk);
        check("reset_held_outputs", outs, 0);
        have_draw = 1'b0;
        have_erase = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_no_start", outs, 0);
        end

        // Free run on an empty course.
        model_reset();
        model_loops(3);
        pulse_start(0);
        finish_run();

        // Bottom hit at (81,62).
        obs_mem[81][62] = 1'b1;
        model_reset();
        model_loops(3);
        pulse_start(2);
        wait_draws(2);
        repeat (6) @(negedge clk);
        check("rdy_probe_sel", s_obs_xy, 1);
        check("rdy_obstacle", obstacle, 1);
        check("rdy_en_ydir", en_ydir, 1);
        finish_run();

        // Corner: both axes reflect in the same loop.
        obs_mem[82][61] = 1'b1;
        model_reset();
        model_loops(3);
        pulse_start(1);
        finish_run();

        // Random courses.
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            for (int k = 0; k < 30; k++)
                obs_mem[$urandom_range(92, 70)][$urandom_range(72, 50)] = 1'b1;
            model_reset();
            model_loops($urandom_range(20, 8));
            pulse_start($urandom_range(5, 0));
            finish_run();
        end

`ifdef OBSTACLE_HIT_COUNT_EN
        // Saturation: every probe hits.
        force_obs = 1'b1;
        sb_en = 1'b0;
        pulse_start(0);
        wait_draws(128);
        check("hits_after_127_loops", hits, 254);
        wait_draws(1);
        check("hits_after_128_loops", hits, 255);
        wait_draws(6);
        check("hits_saturated", hits, 255);
        do_reset();
        force_obs = 1'b0;
        sb_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
